// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the data memory slice.
package mem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Index width for a storage array of the given depth (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_core.sv
// Single-port storage array: synchronous write, synchronous read, no reset.
//   clk   : clock
//   we    : write enable, stores wdata at idx
//   re    : read enable, loads mem[idx] into rdata
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, holds between reads
module sram_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Wait-stated data memory behind the memory-control request interface.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   req   : access request (sampled only while idle)
//   rw    : 1 = write, 0 = read
//   addr  : word address
//   wdata : store data
//   rdata : load data, held until the next completed read
//   busy  : access in progress
//   ready : one-cycle completion pulse
//   err   : completed access was out of range (valid with ready)
module data_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ready,
    output logic              err
);

    localparam int unsigned IDX_W = idx_width(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_zero;
    logic [DATA_W-1:0] sram_rdata;

    logic              fire_c;
    logic              oob_c;
    logic              sram_we_c;
    logic              sram_re_c;

    // Completion strobe and range check on the latched address.
    always_comb begin
        fire_c    = (state == ST_WAIT) && (cnt == '0);
        oob_c     = (32'(addr_q) >= DEPTH);
        // Reset at the completing edge aborts the access.
        sram_we_c = fire_c && rw_q  && !oob_c && !rst;
        sram_re_c = fire_c && !rw_q && !oob_c && !rst;
    end

    // Request FSM, wait counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rd_zero <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        rw_q    <= rw;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= CNT_W'(WAIT_STATES);
                        busy    <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        ready <= 1'b1;
                        err   <= oob_c;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        // A completed read selects the array output, or zero when out of range.
                        if (!rw_q) begin
                            rd_zero <= oob_c;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we_c),
        .re    (sram_re_c),
        .idx   (IDX_W'(addr_q)),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    // The array has no reset, so a registered select forces zero after reset or an out-of-range read.
    assign rdata = rd_zero ? '0 : sram_rdata;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    localparam int unsigned WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        ready;
    logic        err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] model_rdata = '0;
    bit b2b_chk = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    data_memory #(
        .DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input string name, input logic [31:0] rd, input logic e);
        exp_t x;
        x.name = name;
        x.rd   = rd;
        x.e    = e;
        x.cyc  = cyc + int'(WS) + 1;
        sb.push_back(x);
    endtask

    // One access; returns in the cycle before the ready pulse so the next call lands in the ready cycle.
    task automatic access(input string name, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_e);
        @(negedge clk);
        req = 1'b1; rw = w; addr = a; wdata = d;
        @(posedge clk); #1;
        if (!w) model_rdata = exp_rd;
        push(name, model_rdata, exp_e);
        req = 1'b0;
        repeat (WS + 1) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every ready pulse.
    always @(negedge clk) begin
        if (ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk({x.name, "_latency"}, 32'(cyc), 32'(x.cyc));
                chk({x.name, "_err"}, 32'(err), 32'(x.e));
                chk({x.name, "_rdata"}, rdata, x.rd);
            end
        end
        if (b2b_chk) chk("b2b_busy", 32'(busy), 32'(!ready));
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        model_rdata = '0;

        // Known background values.
        access("init0", 1'b1, 16'h0000, 32'hA5A50000, '0, 1'b0);
        access("init5", 1'b1, 16'h0005, 32'h00000505, '0, 1'b0);
        access("init8", 1'b1, 16'h0008, 32'h00000808, '0, 1'b0);
        access("initff", 1'b1, 16'h00FF, 32'hCAFEF00D, '0, 1'b0);

        // Basic write then read.
        access("wr21", 1'b1, 16'h0021, 32'hDEADBEEF, '0, 1'b0);
        access("rd21", 1'b0, 16'h0021, '0, 32'hDEADBEEF, 1'b0);

        // Out of range.
        access("wr100", 1'b1, 16'h0100, 32'h00001234, '0, 1'b1);
        access("rd100", 1'b0, 16'h0100, '0, 32'h00000000, 1'b1);
        access("rd0", 1'b0, 16'h0000, '0, 32'hA5A50000, 1'b0);
        access("rdffff", 1'b0, 16'hFFFF, '0, 32'h00000000, 1'b1);
        access("rdff", 1'b0, 16'h00FF, '0, 32'hCAFEF00D, 1'b0);

        // Request while busy is ignored.
        @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 16'h0022; wdata = 32'h00000011;
        @(posedge clk); #1;
        push("wr22", model_rdata, 1'b0);
        addr = 16'h0005; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("busy_k1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_k2", 32'(busy), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        access("rd5", 1'b0, 16'h0005, '0, 32'h00000505, 1'b0);
        access("rd22", 1'b0, 16'h0022, '0, 32'h00000011, 1'b0);

        // Reset during the wait aborts the write.
        @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 16'h0008; wdata = 32'h00000055;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        repeat (5) @(negedge clk);
        access("rd8", 1'b0, 16'h0008, '0, 32'h00000808, 1'b0);
        repeat (2) @(negedge clk);

        // req held high, alternating reads: one completion every WS+2 cycles.
        @(negedge clk);
        req = 1'b1; rw = 1'b0; addr = 16'h0021;
        @(posedge clk); #1;
        model_rdata = 32'hDEADBEEF;
        push("b2b0", model_rdata, 1'b0);
        b2b_chk = 1'b1;
        for (int i = 1; i < 6; i++) begin
            repeat (WS + 2) @(negedge clk);
            addr = (i % 2 == 1) ? 16'h0000 : 16'h0021;
            @(posedge clk); #1;
            model_rdata = (i % 2 == 1) ? 32'hA5A50000 : 32'hDEADBEEF;
            push($sformatf("b2b%0d", i), model_rdata, 1'b0);
        end
        repeat (WS + 2) @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        b2b_chk = 1'b0;

        repeat (6) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DATA_W, 32, data word width.
REQ-002 SHALL have parameter ADDR_W, 16, address bus width, matching the memory-control address bus.
REQ-003 SHALL have parameter DEPTH, 256, number of words implemented.
REQ-004 SHALL have parameter WAIT_STATES, 2, extra access cycles, range 0..15.
REQ-005 SHALL have port clk input 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-007 SHALL have port req input 1: access request from memory control.
REQ-008 SHALL have port rw input 1: 1 = write (STR), 0 = read (LDR).
REQ-009 SHALL have port addr input ADDR_W: word address.
REQ-010 SHALL have port wdata input DATA_W: store data.
REQ-011 SHALL have port rdata output DATA_W: load data back to memory control.
REQ-012 SHALL have port busy output 1: access in progress.
REQ-013 SHALL have port ready output 1: one-cycle completion pulse.
REQ-014 SHALL have port err output 1: completed access was out of range, valid with ready.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, WAIT.
REQ-016 In IDLE with req=1 at edge k, SHALL latch rw/addr/wdata, load cnt=WAIT_STATES, set busy=1, go to WAIT.
REQ-017 In WAIT with cnt!=0, SHALL decrement cnt; addr/wdata/rw/req inputs ignored.
REQ-018 In WAIT with cnt==0, SHALL perform the access, set ready=1, err=oob, busy=0, go to IDLE.
REQ-019 Latency: request sampled at edge k SHALL produce ready high during the cycle after edge k+WAIT_STATES+1; WAIT_STATES=0 gives ready after edge k+1.
REQ-020 ready and err SHALL be high for exactly one cycle per completion, otherwise 0.
REQ-021 req in the ready cycle SHALL be accepted (IDLE), giving back-to-back throughput of one access per WAIT_STATES+2 cycles.
REQ-022 Write SHALL store latched wdata at mem[addr]; rdata unchanged.
REQ-023 Read SHALL load rdata with mem[addr], updated at the completing edge; rdata holds until the next completed read.
REQ-024 Out of range (addr >= DEPTH): write SHALL NOT modify any word; read SHALL set rdata=0; err=1 in both cases.
REQ-025 req while busy=1 SHALL be ignored with no queuing.
REQ-026 Memory contents SHALL be uninitialised by reset; only the write path modifies them.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, cnt=0, busy=0, ready=0, err=0, rdata=0.
REQ-028 rst in WAIT SHALL abort the access: pending write not performed, no ready pulse.
REQ-029 rst SHALL take priority over req at the same edge.

Structure
REQ-030 Shared package mem_pkg SHALL hold DATA_W, ADDR_W, DEPTH defaults and the FSM state encoding.
REQ-031 Storage SHALL be a sub-module sram_core (single port, synchronous write, synchronous read, no reset); FSM and counter in data_memory.

Verification (DEPTH=256, WAIT_STATES=2)
REQ-032 Reset: rst=1 for 2 cycles -> busy=0, ready=0, err=0, rdata=0.
REQ-033 Write 0xDEADBEEF to 0x0021 (req at edge k), then read 0x0021 -> ready after edge k+3 each time, read rdata=0xDEADBEEF, err=0.
REQ-034 Write 0x00001234 to 0x0100 -> err=1 with ready; read 0x0100 -> rdata=0, err=1; read 0x0000 returns its prior value.
REQ-035 While busy, drive req with write 0xFFFFFFFF to 0x0005 -> ignored; later read 0x0005 returns prior value.
REQ-036 Write 0x55 to 0x0008 with rst asserted in WAIT -> no ready pulse; subsequent read 0x0008 returns prior value.
REQ-037 req held high, alternating reads -> ready pulses exactly every 4 cycles, busy low only in ready cycles.
